mem_wb_stage: RTL and testbench



---
 rtl/mips_pkg.sv | 17 +
 rtl/mem_wb_stage_data_mem_array.sv | 22 ++
 rtl/mem_wb_stage.sv | 147 ++++++++++++++
 tb/tb_mem_wb_stage.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared opcode constants and mem/writeback state encoding
// for the MIPS-style datapath.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  typedef enum logic [1:0] {
    IDLE,
    MEM_WAIT,
    WRITEBACK
  } mw_state_t;

endpackage

// File: rtl/mem_wb_stage_data_mem_array.sv
// Single-port synchronous word RAM with registered read data.
// Contents are not reset.
module data_mem_array #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] dataBank [DEPTH];

  always_ff @(posedge clk) begin
    if (we) dataBank[idx] <= wdata;
    if (re) rdata <= dataBank[idx];
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access / write-back stage: lw/sw against a local RAM
// with fixed latency, plus the register-bank write port.
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int ADDR_BITS   = 6,
  parameter int MEM_LAT     = 2
) (
  input  logic        clk_MW,
  input  logic        rst_MW,
  input  logic        valid_MW,
  input  logic [5:0]  op_MW,
  input  logic [31:0] res_MW,
  input  logic [31:0] storeData_MW,
  input  logic [4:0]  destReg_MW,
  output logic        stall_MW,
  output logic        wbEnable_MW,
  output logic [4:0]  wbReg_MW,
  output logic [31:0] wbData_MW,
  output logic        memFault_MW
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [31:0] LIMIT = 32'(DEPTH_WORDS * 4);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);

  mw_state_t            r_state;
  logic [CW-1:0]        r_cnt;
  logic [ADDR_BITS-1:0] r_idx;
  logic [31:0]          r_sdata;
  logic [4:0]           r_dest;
  logic                 r_isStore;
  logic                 r_stall;
  logic                 r_wbEn;
  logic                 r_fault;
  logic                 r_sel;
  logic [4:0]           r_wbReg;
  logic [31:0]          r_wbData;

  logic        w_alu;
  logic        w_mem;
  logic        w_bad;
  logic        w_last;
  logic        w_we;
  logic        w_re;
  logic [31:0] w_rdata;

  assign w_alu  = (op_MW == OP_RTYPE) || (op_MW == OP_ADDI);
  assign w_mem  = (op_MW == OP_LW) || (op_MW == OP_SW);
  assign w_bad  = (|res_MW[1:0]) || (res_MW >= LIMIT);
  assign w_last = (r_state == MEM_WAIT) && (r_cnt == '0);
  assign w_we   = w_last && r_isStore;
  assign w_re   = w_last && !r_isStore;

  data_mem_array #(
    .DEPTH (DEPTH_WORDS),
    .AW    (ADDR_BITS)
  ) u_mem (
    .clk   (clk_MW),
    .we    (w_we),
    .re    (w_re),
    .idx   (r_idx),
    .wdata (r_sdata),
    .rdata (w_rdata)
  );

  // Load data lands in the RAM read register on the exit edge,
  // so it is forwarded during WRITEBACK and latched afterwards.
  always_ff @(posedge clk_MW or posedge rst_MW) begin
    if (rst_MW) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_sdata   <= '0;
      r_dest    <= '0;
      r_isStore <= 1'b0;
      r_stall   <= 1'b0;
      r_wbEn    <= 1'b0;
      r_fault   <= 1'b0;
      r_sel     <= 1'b0;
      r_wbReg   <= '0;
      r_wbData  <= '0;
    end else begin
      r_wbEn  <= 1'b0;
      r_fault <= 1'b0;
      if (r_sel) begin
        r_wbData <= w_rdata;
        r_sel    <= 1'b0;
      end
      unique case (r_state)
        MEM_WAIT: begin
          if (r_cnt == '0) begin
            r_stall <= 1'b0;
            if (r_isStore) begin
              r_state <= IDLE;
            end else begin
              r_state <= WRITEBACK;
              if (r_dest != 5'd0) begin
                r_wbEn  <= 1'b1;
                r_wbReg <= r_dest;
                r_sel   <= 1'b1;
              end
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          if (valid_MW) begin
            unique case (1'b1)
              w_alu: begin
                if (destReg_MW != 5'd0) begin
                  r_wbEn   <= 1'b1;
                  r_wbReg  <= destReg_MW;
                  r_wbData <= res_MW;
                end
              end
              w_mem: begin
                if (w_bad) begin
                  r_fault <= 1'b1;
                end else begin
                  r_idx     <= res_MW[ADDR_BITS+1:2];
                  r_sdata   <= storeData_MW;
                  r_dest    <= destReg_MW;
                  r_isStore <= (op_MW == OP_SW);
                  r_cnt     <= CNT_LOAD;
                  r_stall   <= 1'b1;
                  r_state   <= MEM_WAIT;
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  assign stall_MW    = r_stall;
  assign wbEnable_MW = r_wbEn;
  assign wbReg_MW    = r_wbReg;
  assign wbData_MW   = r_sel ? w_rdata : r_wbData;
  assign memFault_MW = r_fault;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: queued expected writebacks
// plus per-scenario checks of stall, fault and memory contents.
module tb_mem_wb_stage;
  import mips_pkg::*;

  logic        clk;
  logic        rst;
  logic        valid;
  logic [5:0]  op;
  logic [31:0] res;
  logic [31:0] sdata;
  logic [4:0]  dest;
  logic        stall;
  logic        wbEn;
  logic [4:0]  wbReg;
  logic [31:0] wbData;
  logic        fault;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } wb_t;
  wb_t exp_q[$];

  mem_wb_stage #(
    .DEPTH_WORDS (64),
    .ADDR_BITS   (6),
    .MEM_LAT     (2)
  ) dut (
    .clk_MW       (clk),
    .rst_MW       (rst),
    .valid_MW     (valid),
    .op_MW        (op),
    .res_MW       (res),
    .storeData_MW (sdata),
    .destReg_MW   (dest),
    .stall_MW     (stall),
    .wbEnable_MW  (wbEn),
    .wbReg_MW     (wbReg),
    .wbData_MW    (wbData),
    .memFault_MW  (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      vectors++;
      if (wbEn && fault) begin
        miscompares++;
        $display("FAIL wb_fault_overlap wb=%b fault=%b want not both", wbEn, fault);
      end
      if (wbEn) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_wb reg=%0d data=%h want no writeback", wbReg, wbData);
        end else begin
          wb_t e;
          e = exp_q.pop_front();
          if (wbReg !== e.r || wbData !== e.d) begin
            miscompares++;
            $display("FAIL wb_scoreboard got reg=%0d data=%h want reg=%0d data=%h",
                     wbReg, wbData, e.r, e.d);
          end
        end
      end
    end
  end

  task automatic issue(input logic [5:0] o, input logic [31:0] r,
                       input logic [31:0] s, input logic [4:0] d);
    valid = 1'b1; op = o; res = r; sdata = s; dest = d;
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic wait_stall(output int n);
    n = 0;
    while (stall && n < 20) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; valid = 1'b0; op = '0; res = '0; sdata = '0; dest = '0;
    #1;
    vectors++;
    if ({stall, wbEn, wbReg, wbData, fault} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got stall=%b wb=%b reg=%0d data=%h fault=%b want all 0",
               stall, wbEn, wbReg, wbData, fault);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_alu_b2b;
    logic [31:0] vals [4];
    logic [4:0]  regs [4];
    vals = '{32'h2A, 32'h1, 32'h2, 32'h3};
    regs = '{5'd5, 5'd6, 5'd7, 5'd8};
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{regs[i], vals[i]});
      valid = 1'b1; op = (i % 2) ? OP_ADDI : OP_RTYPE;
      res = vals[i]; dest = regs[i];
      @(posedge clk); #1;
      vectors++;
      if (wbEn !== 1'b1 || stall !== 1'b0) begin
        miscompares++;
        $display("FAIL alu_b2b_%0d got wb=%b stall=%b want wb=1 stall=0", i, wbEn, stall);
      end
    end
    valid = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (wbEn !== 1'b0 || wbData !== 32'h3) begin
      miscompares++;
      $display("FAIL alu_idle got wb=%b data=%h want wb=0 data=3", wbEn, wbData);
    end
  endtask

  task automatic test_sw_lw;
    int n;
    issue(OP_SW, 32'h10, 32'hDEADBEEF, 5'd0);
    wait_stall(n);
    vectors++;
    if (n != 2 || dut.u_mem.dataBank[4] !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL sw_basic got stall=%0d bank4=%h want 2 deadbeef", n, dut.u_mem.dataBank[4]);
    end
    exp_q.push_back('{5'd8, 32'hDEADBEEF});
    issue(OP_LW, 32'h10, 32'h0, 5'd8);
    wait_stall(n);
    vectors++;
    if (n != 2 || wbEn !== 1'b1 || wbReg !== 5'd8 || wbData !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL lw_basic got stall=%0d wb=%b reg=%0d data=%h want 2 1 8 deadbeef",
               n, wbEn, wbReg, wbData);
    end
    @(posedge clk); #1;
    vectors++;
    if (wbEn !== 1'b0 || wbData !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL lw_hold got wb=%b data=%h want 0 deadbeef", wbEn, wbData);
    end
  endtask

  task automatic test_fault;
    logic [31:0] addrs [2];
    addrs = '{32'h13, 32'h100};
    for (int i = 0; i < 2; i++) begin
      issue(OP_LW, addrs[i], 32'h0, 5'd9);
      vectors++;
      if (fault !== 1'b1 || stall !== 1'b0 || wbEn !== 1'b0) begin
        miscompares++;
        $display("FAIL fault_pulse_%0d got fault=%b stall=%b wb=%b want 1 0 0",
                 i, fault, stall, wbEn);
      end
      @(posedge clk); #1;
      vectors++;
      if (fault !== 1'b0 || stall !== 1'b0 || wbData !== 32'hDEADBEEF) begin
        miscompares++;
        $display("FAIL fault_after_%0d got fault=%b stall=%b data=%h want 0 0 deadbeef",
                 i, fault, stall, wbData);
      end
    end
  endtask

  task automatic test_reg0;
    int n;
    issue(OP_ADDI, 32'h55, 32'h0, 5'd0);
    vectors++;
    if (wbEn !== 1'b0 || wbData !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL addi_r0 got wb=%b data=%h want 0 deadbeef", wbEn, wbData);
    end
    issue(OP_LW, 32'h10, 32'h0, 5'd0);
    wait_stall(n);
    vectors++;
    if (n != 2 || wbEn !== 1'b0) begin
      miscompares++;
      $display("FAIL lw_r0 got stall=%0d wb=%b want 2 0", n, wbEn);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int n;
    issue(OP_SW, 32'h20, 32'hCAFEF00D, 5'd0);
    wait_stall(n);
    issue(OP_SW, 32'h20, 32'h12345678, 5'd0);
    rst = 1'b1;
    #1;
    vectors++;
    if ({stall, wbEn, wbReg, wbData, fault} !== '0 || dut.r_state !== IDLE) begin
      miscompares++;
      $display("FAIL reset_mid got stall=%b wb=%b reg=%0d data=%h fault=%b want all 0 idle",
               stall, wbEn, wbReg, wbData, fault);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    vectors++;
    if (dut.u_mem.dataBank[8] !== 32'hCAFEF00D || stall !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_abort got bank8=%h stall=%b want cafef00d 0",
               dut.u_mem.dataBank[8], stall);
    end
  endtask

  task automatic test_noeffect;
    int n;
    logic [5:0] ops [2];
    ops = '{OP_BEQ, 6'b111111};
    for (int i = 0; i < 2; i++) begin
      issue(ops[i], 32'h10, 32'h0, 5'd4);
      vectors++;
      if (stall !== 1'b0 || wbEn !== 1'b0 || fault !== 1'b0) begin
        miscompares++;
        $display("FAIL noop_%0d got stall=%b wb=%b fault=%b want 0 0 0", i, stall, wbEn, fault);
      end
    end
    issue(OP_SW, 32'h34, 32'h13131313, 5'd0);
    wait_stall(n);
    issue(OP_SW, 32'h30, 32'hA5A5A5A5, 5'd0);
    n = 0;
    while (stall && n < 20) begin
      n++;
      valid = 1'b1; op = (n % 2) ? OP_SW : OP_RTYPE;
      res = 32'h34; sdata = 32'hFFFFFFFF; dest = 5'd3;
      @(posedge clk); #1;
    end
    valid = 1'b0;
    vectors++;
    if (n != 2 || dut.u_mem.dataBank[12] !== 32'hA5A5A5A5 ||
        dut.u_mem.dataBank[13] !== 32'h13131313 || wbEn !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_ignore got stall=%0d b12=%h b13=%h wb=%b want 2 a5a5a5a5 13131313 0",
               n, dut.u_mem.dataBank[12], dut.u_mem.dataBank[13], wbEn);
    end
    exp_q.push_back('{5'd10, 32'hA5A5A5A5});
    issue(OP_LW, 32'h30, 32'h0, 5'd10);
    wait_stall(n);
    @(posedge clk); #1;
    vectors++;
    if (wbData !== 32'hA5A5A5A5 || wbReg !== 5'd10) begin
      miscompares++;
      $display("FAIL lw_after_ignore got reg=%0d data=%h want 10 a5a5a5a5", wbReg, wbData);
    end
  endtask

  initial begin
    test_reset;
    test_alu_b2b;
    test_sw_lw;
    test_fault;
    test_reg0;
    test_reset_mid;
    test_noeffect;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL missing_wb got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
